// File: rtl/hqm_aw_rf_pkg.sv
// Shared types and helpers for the AW-level init-swept register file.
// Parity storage is enabled by defining HQM_AW_RF_PARITY_EN.
package hqm_aw_rf_pkg;

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } rf_init_state_t;

    localparam int RF_RD_LAT_MAX = 2;
    localparam int RF_PAR_W      = 128;

    // Even parity; callers zero-extend narrower words, which leaves parity unchanged.
    function automatic logic rf_par(input logic [RF_PAR_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/hqm_aw_rf_array.sv
// 1W/1R storage: synchronous write, combinational read, no reset.
// Kept isolated so it can be replaced by an RF macro.
module hqm_aw_rf_array #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 20,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/hqm_aw_rf_init_pipe.sv
// Register file with post-reset init sweep, RD_LAT 1/2 read pipe and write-first bypass.
// Optional stored parity per entry when HQM_AW_RF_PARITY_EN is defined.
module hqm_aw_rf_init_pipe
    import hqm_aw_rf_pkg::*;
#(
    parameter int               DEPTH    = 256,
    parameter int               WIDTH    = 20,
    parameter int               RD_LAT   = 1,
    parameter logic [WIDTH-1:0] INIT_VAL = '0,
    parameter int               AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             init_busy,
    output logic             init_done,
    output logic             rperr
);

    localparam int LAT = (RD_LAT >= RF_RD_LAT_MAX) ? RF_RD_LAT_MAX : 1;

`ifdef HQM_AW_RF_PARITY_EN
    localparam int AWD = WIDTH + 1;
`else
    localparam int AWD = WIDTH;
`endif

    rf_init_state_t   state;
    rf_init_state_t   state_nxt;
    logic [AW-1:0]    init_ptr;
    logic [AWD-1:0]   init_word;
    logic [AWD-1:0]   user_word;
    logic [AWD-1:0]   arr_wdata;
    logic [AWD-1:0]   arr_rdata;
    logic [AWD-1:0]   rd_word;
    logic [AW-1:0]    arr_waddr;
    logic             arr_we;
    logic             rd_acc;
    logic             wr_acc;
    logic             coll;
    logic             v1;
    logic [AWD-1:0]   d1;
    logic             vout;
    logic [AWD-1:0]   dout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            INIT:    if (&init_ptr) state_nxt = IDLE;
            IDLE:    state_nxt = IDLE;
            default: state_nxt = INIT;
        endcase
    end

    // The FSM only leaves INIT at sweep end and only re-enters on rst, so done is sticky.
    always_comb begin
        init_busy = (state == INIT);
        init_done = (state == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_ptr <= '0;
        end else if (init_busy) begin
            init_ptr <= init_ptr + 1'b1;
        end
    end

`ifdef HQM_AW_RF_PARITY_EN
    assign init_word = {rf_par(RF_PAR_W'(INIT_VAL)), INIT_VAL};
    assign user_word = {rf_par(RF_PAR_W'(wdata)), wdata};
`else
    assign init_word = INIT_VAL;
    assign user_word = wdata;
`endif

    assign rd_acc    = re & ~init_busy;
    assign wr_acc    = we & ~init_busy;
    assign coll      = rd_acc & wr_acc & (raddr == waddr);
    assign arr_we    = init_busy | wr_acc;
    assign arr_waddr = init_busy ? init_ptr : waddr;
    assign arr_wdata = init_busy ? init_word : user_word;

    hqm_aw_rf_array #(
        .DEPTH (DEPTH),
        .WIDTH (AWD),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .raddr (raddr),
        .rdata (arr_rdata)
    );

    assign rd_word = coll ? user_word : arr_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            d1 <= '0;
        end else begin
            v1 <= rd_acc;
            if (rd_acc) d1 <= rd_word;
        end
    end

    if (LAT == 2) begin : g_lat2
        logic           v2;
        logic [AWD-1:0] d2;

        always_ff @(posedge clk) begin
            if (rst) begin
                v2 <= 1'b0;
                d2 <= '0;
            end else begin
                v2 <= v1;
                if (v1) d2 <= d1;
            end
        end

        assign vout = v2;
        assign dout = d2;
    end else begin : g_lat1
        assign vout = v1;
        assign dout = d1;
    end

    assign rvalid = vout;
    assign rdata  = dout[WIDTH-1:0];

`ifdef HQM_AW_RF_PARITY_EN
    assign rperr = rf_par(RF_PAR_W'(dout[WIDTH-1:0])) ^ dout[WIDTH];
`else
    assign rperr = 1'b0;
`endif

endmodule

// File: tb/tb_hqm_aw_rf_init_pipe.sv
// Directed bench: RD_LAT=1 and RD_LAT=2 instances share one stimulus stream.
// Parity injection runs only when HQM_AW_RF_PARITY_EN is defined.
module tb_hqm_aw_rf_init_pipe;

    localparam int               DEPTH = 16;
    localparam int               WIDTH = 20;
    localparam int               AW    = 4;
    localparam logic [WIDTH-1:0] IVAL  = 20'hA5A5A;

    logic             clk;
    logic             rst;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic             re;
    logic [AW-1:0]    raddr;

    logic [WIDTH-1:0] rdata1, rdata2;
    logic             rvalid1, rvalid2;
    logic             busy1, busy2;
    logic             done1, done2;
    logic             perr1, perr2;

    logic [WIDTH-1:0] model [DEPTH];
    int               n_cmp;
    int               n_err;

    hqm_aw_rf_init_pipe #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .RD_LAT(1), .INIT_VAL(IVAL)
    ) dut1 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata1), .rvalid(rvalid1),
        .init_busy(busy1), .init_done(done1), .rperr(perr1)
    );

    hqm_aw_rf_init_pipe #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .RD_LAT(2), .INIT_VAL(IVAL)
    ) dut2 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata2), .rvalid(rvalid2),
        .init_busy(busy2), .init_done(done2), .rperr(perr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset();
        chk("rst_rvalid1", 32'(rvalid1), 32'd0);
        chk("rst_rvalid2", 32'(rvalid2), 32'd0);
        chk("rst_rdata1", 32'(rdata1), 32'd0);
        chk("rst_rdata2", 32'(rdata2), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd1);
        chk("rst_busy2", 32'(busy2), 32'd1);
        chk("rst_done1", 32'(done1), 32'd0);
        chk("rst_perr1", 32'(perr1), 32'd0);
    endtask

    // Releases reset and counts busy cycles; optionally hammers re/we on addr 2.
    task automatic run_sweep(input logic poke);
        int n1;
        int n2;
        logic any_rv;
        n1 = 0;
        n2 = 0;
        any_rv = 1'b0;
        rst = 1'b0;
        for (int c = 0; c < DEPTH + 2; c++) begin
            if (busy1) n1++;
            if (busy2) n2++;
            we    = poke && (c < DEPTH);
            re    = poke && (c < DEPTH);
            waddr = 4'd2;
            raddr = 4'd2;
            wdata = 20'h11111;
            @(negedge clk);
            if (rvalid1 || rvalid2) any_rv = 1'b1;
        end
        we = 1'b0;
        re = 1'b0;
        chk("busy_cycles1", 32'(n1), 32'(DEPTH));
        chk("busy_cycles2", 32'(n2), 32'(DEPTH));
        chk("init_done1", 32'(done1), 32'd1);
        chk("init_done2", 32'(done2), 32'd1);
        chk("init_busy_end", 32'(busy1), 32'd0);
        chk("init_no_rvalid", 32'(any_rv), 32'd0);
    endtask

    // Streams one read per cycle over all entries and checks both latencies.
    task automatic read_all();
        for (int k = 0; k <= DEPTH + 1; k++) begin
            re    = (k < DEPTH);
            raddr = AW'(k);
            @(negedge clk);
            chk("l1_rvalid", 32'(rvalid1), 32'(k < DEPTH));
            if (k < DEPTH) begin
                chk("l1_rdata", 32'(rdata1), 32'(model[k]));
                chk("l1_rperr", 32'(perr1), 32'd0);
            end
            chk("l2_rvalid", 32'(rvalid2), 32'(k >= 1 && k <= DEPTH));
            if (k >= 1 && k <= DEPTH) begin
                chk("l2_rdata", 32'(rdata2), 32'(model[k-1]));
                chk("l2_rperr", 32'(perr2), 32'd0);
            end
        end
        re = 1'b0;
    endtask

    task automatic write1(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        @(negedge clk);
        we = 1'b0;
        model[a] = d;
    endtask

    // Single read (optionally with a same-address write) and latency check.
    task automatic read1(input logic [AW-1:0] a, input logic wr,
                         input logic [WIDTH-1:0] d, input string tag);
        re    = 1'b1;
        raddr = a;
        we    = wr;
        waddr = a;
        wdata = d;
        @(negedge clk);
        re = 1'b0;
        we = 1'b0;
        if (wr) model[a] = d;
        chk({tag, "_l1_rvalid"}, 32'(rvalid1), 32'd1);
        chk({tag, "_l1_rdata"}, 32'(rdata1), 32'(model[a]));
        chk({tag, "_l2_early"}, 32'(rvalid2), 32'd0);
        @(negedge clk);
        chk({tag, "_l1_drop"}, 32'(rvalid1), 32'd0);
        chk({tag, "_l1_hold"}, 32'(rdata1), 32'(model[a]));
        chk({tag, "_l2_rvalid"}, 32'(rvalid2), 32'd1);
        chk({tag, "_l2_rdata"}, 32'(rdata2), 32'(model[a]));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        we    = 1'b0;
        re    = 1'b0;
        waddr = '0;
        wdata = '0;
        raddr = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = IVAL;

        @(negedge clk);
        @(negedge clk);
        check_reset();
        run_sweep(1'b1);
        read_all();

        write1(4'd3, 20'h12345);
        read1(4'd3, 1'b0, '0, "basic");
        read1(4'd5, 1'b1, 20'hFFFFF, "coll");
        chk("coll_stored", 32'(dut1.u_array.mem[5][WIDTH-1:0]), 32'hFFFFF);
        read_all();
        chk("hold_rdata1", 32'(rdata1), 32'(model[DEPTH-1]));
        chk("hold_rdata2", 32'(rdata2), 32'(model[DEPTH-1]));

        write1(4'd0, 20'h0BEEF);
        write1(4'd15, 20'h54321);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (7) @(negedge clk);
        chk("mid_busy", 32'(busy1), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset();
        for (int i = 0; i < DEPTH; i++) model[i] = IVAL;
        run_sweep(1'b0);
        read_all();

`ifdef HQM_AW_RF_PARITY_EN
        begin
            logic pbit;
            pbit = dut1.u_array.mem[9][WIDTH];
            force dut1.u_array.mem[9][WIDTH] = ~pbit;
            re    = 1'b1;
            raddr = 4'd9;
            @(negedge clk);
            re = 1'b0;
            chk("par_rvalid", 32'(rvalid1), 32'd1);
            chk("par_rperr", 32'(perr1), 32'd1);
            release dut1.u_array.mem[9][WIDTH];
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
